// File: rtl/pll_reconfig_pkg.sv
// PLL reconfiguration controller: shared state encoding, register
// addresses and default C-counter words.
package pll_reconfig_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_C,
    GAP,
    WR_GO,
    SETTLE,
    WAIT_LOCK
  } state_t;

  localparam logic [5:0]  ADDR_C      = 6'h05;
  localparam logic [5:0]  ADDR_GO     = 6'h02;
  localparam logic [31:0] GO_DATA     = 32'h0000_0001;
  localparam logic [31:0] C_ORIG_DFLT = 32'h0000_0A0A;
  localparam logic [31:0] C_60HZ_DFLT = 32'h0002_0A09;

endpackage

// File: rtl/pll_reconfig_ctrl_sync.sv
// pll_sync2: two-flop synchronizer for single-bit asynchronous inputs,
// cleared by the asynchronous active-low reset.
module pll_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration controller: programs the C counter and starts
// reconfiguration. Optional lock timeout: define PLL_LOCK_TIMEOUT_EN.
module pll_reconfig_ctrl
  import pll_reconfig_pkg::*;
#(
  parameter logic [31:0] C_ORIG       = C_ORIG_DFLT,
  parameter logic [31:0] C_60HZ       = C_60HZ_DFLT,
  parameter int          SETTLE_CYC   = 16,
  parameter int          LOCK_TIMEOUT = 1048576
) (
  input  logic        CLK_50M,
  input  logic        RESET_n,
  input  logic        freq_sel,
  input  logic        pll_locked,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        busy,
  output logic        new_vmode,
  output logic        lock_err
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  state_t state, nxt;

  logic          freq_s, lock_s;
  logic          init_pend, sel_q, applied, vmode_q;
  logic [SW-1:0] settle_cnt;
  logic          settle_done, launch, tmo_hit;

  pll_sync2 u_sync_freq (
    .clk   (CLK_50M),
    .rst_n (RESET_n),
    .d     (freq_sel),
    .q     (freq_s)
  );

  pll_sync2 u_sync_lock (
    .clk   (CLK_50M),
    .rst_n (RESET_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign launch      = (state == IDLE) && (nxt == WR_C);
  assign busy        = (state != IDLE);
  assign new_vmode   = vmode_q;

  always_ff @(posedge CLK_50M or negedge RESET_n) begin
    if (!RESET_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (init_pend || (freq_s != applied)) nxt = WR_C;
      WR_C:
        if (!mgmt_waitrequest) nxt = GAP;
      GAP:
        nxt = WR_GO;
      WR_GO:
        if (!mgmt_waitrequest) nxt = SETTLE;
      SETTLE:
        if (settle_done) nxt = WAIT_LOCK;
      WAIT_LOCK:
        if (lock_s)       nxt = IDLE;
        else if (tmo_hit) nxt = WR_C;
      default:
        nxt = IDLE;
    endcase
  end

  // Strobe, address and data are pure decodes of the state, so they stay
  // stable across waitrequest stalls and drop the moment reset asserts.
  always_comb begin
    mgmt_write     = 1'b0;
    mgmt_address   = '0;
    mgmt_writedata = '0;
    unique case (state)
      WR_C: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_C;
        mgmt_writedata = sel_q ? C_60HZ : C_ORIG;
      end
      WR_GO: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_GO;
        mgmt_writedata = GO_DATA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge RESET_n) begin
    if (!RESET_n) begin
      init_pend  <= 1'b1;
      sel_q      <= 1'b0;
      applied    <= 1'b0;
      vmode_q    <= 1'b0;
      settle_cnt <= '0;
    end else begin
      if (launch) begin
        sel_q     <= freq_s;
        init_pend <= 1'b0;
      end
      if (state == SETTLE) settle_cnt <= settle_cnt + 1'b1;
      else                 settle_cnt <= '0;
      if ((state == WAIT_LOCK) && lock_s) begin
        applied <= sel_q;
        vmode_q <= ~vmode_q;
      end
    end
  end

`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  assign lock_err = err_q;

  always_ff @(posedge CLK_50M or negedge RESET_n) begin
    if (!RESET_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == WAIT_LOCK) tmo_cnt <= tmo_cnt + 1'b1;
      else                    tmo_cnt <= '0;
      if ((state == WAIT_LOCK) && !lock_s && tmo_hit)
        err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit  = 1'b0;
  assign lock_err = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Scoreboard bench for pll_reconfig_ctrl: expected writes and new_vmode
// values are queued at stimulus time and popped by a negedge monitor.
module tb_pll_reconfig_ctrl;

  localparam int TMO = 64;
  localparam logic [31:0] W_ORIG = 32'h0000_0A0A;
  localparam logic [31:0] W_60   = 32'h0002_0A09;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freq_sel = 1'b0;
  logic        pll_locked = 1'b0;
  logic        waitreq = 1'b0;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        busy, new_vmode, lock_err;

  pll_reconfig_ctrl #(
    .SETTLE_CYC   (16),
    .LOCK_TIMEOUT (TMO)
  ) dut (
    .CLK_50M          (clk),
    .RESET_n          (rst_n),
    .freq_sel         (freq_sel),
    .pll_locked       (pll_locked),
    .mgmt_waitrequest (waitreq),
    .mgmt_write       (mgmt_write),
    .mgmt_address     (mgmt_address),
    .mgmt_writedata   (mgmt_writedata),
    .busy             (busy),
    .new_vmode        (new_vmode),
    .lock_err         (lock_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t  exp_wr[$];
  logic exp_vm[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic vm_exp = 1'b0;
  logic sched = 1'b0;
  int   toggles = 0;
  int   c_len = 0;
  int   stall_left = 0;
  bit   rand_wr = 0;
  bit   go_stall = 0;
  bit   lock_hold = 0;
  event go_evt;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d",
               name, act, req, cyc);
    end
  endtask

  // Reference: every reconfiguration is one C write then one GO write,
  // and new_vmode flips once when it completes.
  task automatic push_seq(input logic v);
    exp_wr.push_back('{6'h05, v ? W_60 : W_ORIG});
    exp_wr.push_back('{6'h02, 32'h1});
    vm_exp = ~vm_exp;
    exp_vm.push_back(vm_exp);
  endtask

  task automatic set_freq(input logic v);
    @(posedge clk);
    #1 freq_sel = v;
    if (v != sched) begin
      push_seq(v);
      sched = v;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (4) @(negedge clk);
    while ((busy || exp_wr.size() != 0 || exp_vm.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < 5000, 1);
  endtask

  // waitrequest driver
  always @(posedge clk) begin
    #1;
    if (stall_left > 0 && mgmt_write && mgmt_address == 6'h05) begin
      waitreq = 1'b1;
      stall_left--;
    end else if (go_stall && mgmt_write && mgmt_address == 6'h02)
      waitreq = 1'b1;
    else if (rand_wr)
      waitreq = ($urandom_range(0, 3) == 0);
    else
      waitreq = 1'b0;
  end

  // PLL model: lock drops on the start write and returns after a delay
  always begin
    int d;
    @(go_evt);
    if (!lock_hold) begin
      pll_locked = 1'b0;
      d = $urandom_range(1, 40);
      repeat (d) @(posedge clk);
      #1;
      if (!lock_hold) pll_locked = 1'b1;
    end
  end

  // Monitor
  logic        prev_write = 0, prev_wait = 0, prev_vm = 0;
  logic [5:0]  prev_addr = 0, last_addr = 0;
  logic [31:0] prev_data = 0;
  int          wr_start = 0, last_done = 0;

  always @(negedge clk) begin
    wr_t e;
    if (!rst_n) begin
      prev_write = 0;
      prev_wait  = 0;
      prev_vm    = 0;
      last_addr  = 0;
    end else begin
      if (prev_write && prev_wait)
        check("stall_hold", {mgmt_write, mgmt_address, mgmt_writedata},
              {1'b1, prev_addr, prev_data});
      if (mgmt_write && !prev_write) begin
        wr_start = cyc;
        if (mgmt_address == 6'h02 && last_addr == 6'h05)
          check("gap_len", cyc - last_done, 2);
      end
      if (mgmt_write && !waitreq) begin
        if (exp_wr.size() == 0)
          check("unexpected_wr", {mgmt_address, mgmt_writedata}, 0);
        else begin
          e = exp_wr.pop_front();
          check("wr_addr", mgmt_address, e.a);
          check("wr_data", mgmt_writedata, e.d);
        end
        last_addr = mgmt_address;
        last_done = cyc;
        if (mgmt_address == 6'h05) c_len = cyc - wr_start + 1;
        if (mgmt_address == 6'h02) ->go_evt;
      end
      if (new_vmode !== prev_vm) begin
        toggles++;
        if (exp_vm.size() == 0)
          check("unexpected_vmode", new_vmode, prev_vm);
        else
          check("vmode", new_vmode, exp_vm.pop_front());
      end
      prev_write = mgmt_write;
      prev_wait  = waitreq;
      prev_addr  = mgmt_address;
      prev_data  = mgmt_writedata;
      prev_vm    = new_vmode;
    end
  end

  initial begin
    int n, t0;
    logic v, vm0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_write", mgmt_write, 0);
    check("rst_addr", mgmt_address, 0);
    check("rst_data", mgmt_writedata, 0);
    check("rst_vmode", new_vmode, 0);
    check("rst_busy", busy, 0);
    check("rst_lock_err", lock_err, 0);

    // init pass
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_seq(1'b0);
    wait_idle();
    check("init_vmode", new_vmode, 1);
    check("init_busy", busy, 0);

    // switch to 60 Hz with a 5-cycle stall on the C write
    stall_left = 5;
    set_freq(1'b1);
    n = 0;
    while (!mgmt_write && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("start_latency_ok", n <= 4, 1);
    wait_idle();
    check("stall_c_len", c_len, 6);
    check("switch_busy", busy, 0);
    check("switch_vmode", new_vmode, vm_exp);

    // back to original, then 0->1 and 1->0 again during SETTLE
    set_freq(1'b0);
    wait_idle();
    t0 = toggles;
    set_freq(1'b1);
    @(go_evt);
    repeat (6) @(posedge clk);
    set_freq(1'b0);
    wait_idle();
    check("midseq_toggles", toggles - t0, 2);
    check("midseq_busy", busy, 0);

    // randomized switching with random stalls
    rand_wr = 1;
    for (int i = 0; i < 12; i++) begin
      v = 1'($urandom_range(0, 1));
      set_freq(v);
      wait_idle();
      check("rand_vmode", new_vmode, vm_exp);
    end
    rand_wr = 0;

`ifdef PLL_LOCK_TIMEOUT_EN
    lock_hold = 1;
    pll_locked = 1'b0;
    vm0 = new_vmode;
    v = ~sched;
    set_freq(v);
    exp_wr.push_back('{6'h05, v ? W_60 : W_ORIG});
    exp_wr.push_back('{6'h02, 32'h1});
    n = 0;
    while (!lock_err && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("tmo_lock_err", lock_err, 1);
    check("tmo_vmode_kept", new_vmode, vm0);
    lock_hold = 0;
    wait_idle();
    check("tmo_sticky", lock_err, 1);
`else
    vm0 = new_vmode;
    check("no_tmo_lock_err", lock_err, 0);
`endif

    // reset while the start write is stalled
    go_stall = 1;
    set_freq(~sched);
    n = 0;
    while (!(mgmt_write && mgmt_address == 6'h02) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("go_reached", n < 200, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_drop_write", mgmt_write, 0);
    check("rst_clr_lock_err", lock_err, 0);
    check("rst_clr_vmode", new_vmode, 0);
    exp_wr.delete();
    exp_vm.delete();
    go_stall = 0;
    vm_exp = 1'b0;
    sched = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push_seq(1'b0);
    if (freq_sel) begin
      push_seq(1'b1);
      sched = 1'b1;
    end
    wait_idle();
    check("reinit_vmode", new_vmode, vm_exp);
    check("reinit_busy", busy, 0);
    check("queues_empty", exp_wr.size() + exp_vm.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
